// File: rtl/tl_shrink_pkg.sv
`default_nettype none
//==============================================================================
// tl_shrink_pkg: TileLink opcodes, widths and beat-count helper for the source shrinker.
// Rev 1.0
//==============================================================================
package tl_shrink_pkg;

  localparam int TL_SLOTS      = 4;
  localparam int TL_IN_SRC_W   = 5;
  localparam int TL_OUT_SRC_W  = 2;
  localparam int TL_ADDR_W     = 31;
  localparam int TL_DATA_W     = 32;
  localparam int TL_SIZE_W     = 3;
  localparam int TL_BEAT_CNT_W = 6;

  localparam logic [2:0] TL_A_PUT_FULL        = 3'd0;
  localparam logic [2:0] TL_A_PUT_PARTIAL     = 3'd1;
  localparam logic [2:0] TL_A_GET             = 3'd4;
  localparam logic [2:0] TL_D_ACCESS_ACK      = 3'd0;
  localparam logic [2:0] TL_D_ACCESS_ACK_DATA = 3'd1;

  // Number of 4-byte beats carried by a message of 2**size bytes.
  function automatic logic [TL_BEAT_CNT_W-1:0] tl_beats(input logic [TL_SIZE_W-1:0] size);
    if (size <= TL_SIZE_W'(2)) return TL_BEAT_CNT_W'(1);
    return TL_BEAT_CNT_W'(1) << (size - TL_SIZE_W'(2));
  endfunction

endpackage
`default_nettype wire

// File: rtl/tl_shrink_slot_alloc.sv
`default_nettype none
//==============================================================================
// tl_shrink_slot_alloc: in-flight valid vector with lowest-free-slot encoder.
// Rev 1.0
//==============================================================================
module tl_shrink_slot_alloc #(
  parameter int SLOTS = 4,
  parameter int IDX_W = $clog2(SLOTS)
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             i_set_en,
  input  logic [IDX_W-1:0] i_set_idx,
  input  logic             i_clr_en,
  input  logic [IDX_W-1:0] i_clr_idx,
  output logic [SLOTS-1:0] o_valid,
  output logic [IDX_W-1:0] o_free_idx,
  output logic             o_free_any
);

  logic [SLOTS-1:0] r_valid;
  logic [IDX_W-1:0] w_free_idx;

  // Set is applied after clear so an allocation always wins.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_valid <= '0;
    end else begin
      if (i_clr_en) r_valid[i_clr_idx] <= 1'b0;
      if (i_set_en) r_valid[i_set_idx] <= 1'b1;
    end
  end

  always_comb begin
    w_free_idx = '0;
    for (int i = SLOTS - 1; i >= 0; i--) begin
      if (!r_valid[i]) w_free_idx = IDX_W'(i);
    end
  end

  assign o_valid    = r_valid;
  assign o_free_idx = w_free_idx;
  assign o_free_any = ~&r_valid;

endmodule
`default_nettype wire

// File: rtl/tl_source_shrinker.sv
`default_nettype none
//==============================================================================
// tl_source_shrinker: maps wide TileLink A sources onto a small slot ID and restores them on D.
// Optional macro TL_SOURCE_SHRINK_CHECK_EN adds sticky err_stray and drops D beats to idle slots.
// Rev 1.0
//==============================================================================
module tl_source_shrinker
  import tl_shrink_pkg::*;
#(
  parameter int SLOTS     = TL_SLOTS,
  parameter int IN_SRC_W  = TL_IN_SRC_W,
  parameter int OUT_SRC_W = $clog2(SLOTS),
  parameter int ADDR_W    = TL_ADDR_W,
  parameter int DATA_W    = TL_DATA_W,
  parameter int SIZE_W    = TL_SIZE_W
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  in_a_valid,
  output logic                  in_a_ready,
  input  logic [2:0]            in_a_opcode,
  input  logic [2:0]            in_a_param,
  input  logic [SIZE_W-1:0]     in_a_size,
  input  logic [IN_SRC_W-1:0]   in_a_source,
  input  logic [ADDR_W-1:0]     in_a_address,
  input  logic [DATA_W/8-1:0]   in_a_mask,
  input  logic [DATA_W-1:0]     in_a_data,
  input  logic                  in_a_corrupt,
  output logic                  out_a_valid,
  input  logic                  out_a_ready,
  output logic [2:0]            out_a_opcode,
  output logic [2:0]            out_a_param,
  output logic [SIZE_W-1:0]     out_a_size,
  output logic [OUT_SRC_W-1:0]  out_a_source,
  output logic [ADDR_W-1:0]     out_a_address,
  output logic [DATA_W/8-1:0]   out_a_mask,
  output logic [DATA_W-1:0]     out_a_data,
  output logic                  out_a_corrupt,
  input  logic                  in_d_valid,
  output logic                  in_d_ready,
  input  logic [2:0]            in_d_opcode,
  input  logic [1:0]            in_d_param,
  input  logic [SIZE_W-1:0]     in_d_size,
  input  logic [OUT_SRC_W-1:0]  in_d_source,
  input  logic                  in_d_sink,
  input  logic                  in_d_denied,
  input  logic                  in_d_corrupt,
  input  logic [DATA_W-1:0]     in_d_data,
  output logic                  out_d_valid,
  input  logic                  out_d_ready,
  output logic [2:0]            out_d_opcode,
  output logic [1:0]            out_d_param,
  output logic [SIZE_W-1:0]     out_d_size,
  output logic [IN_SRC_W-1:0]   out_d_source,
  output logic                  out_d_sink,
  output logic                  out_d_denied,
  output logic                  out_d_corrupt,
  output logic [DATA_W-1:0]     out_d_data,
  output logic                  busy
`ifdef TL_SOURCE_SHRINK_CHECK_EN
  ,
  output logic                  err_stray
`endif
);

  logic [SLOTS-1:0]         w_valid;
  logic [OUT_SRC_W-1:0]     w_free_idx;
  logic                     w_free_any;
  logic                     w_a_gate, w_a_fire, w_alloc, w_a_multi;
  logic                     w_d_stray, w_d_fire, w_d_multi, w_d_last;
  logic                     r_a_locked;
  logic [OUT_SRC_W-1:0]     r_a_slot;
  logic [TL_BEAT_CNT_W-1:0] r_a_cnt;
  logic [TL_BEAT_CNT_W-1:0] r_d_cnt;
  logic [IN_SRC_W-1:0]      r_src_tab [SLOTS];

  tl_shrink_slot_alloc #(
    .SLOTS (SLOTS),
    .IDX_W (OUT_SRC_W)
  ) u_slot_alloc (
    .clock      (clock),
    .reset_n    (reset_n),
    .i_set_en   (w_alloc),
    .i_set_idx  (w_free_idx),
    .i_clr_en   (w_d_fire & w_d_last),
    .i_clr_idx  (in_d_source),
    .o_valid    (w_valid),
    .o_free_idx (w_free_idx),
    .o_free_any (w_free_any)
  );

  // A path: later beats of a locked burst bypass the free-slot gate.
  assign w_a_gate     = r_a_locked | w_free_any;
  assign out_a_valid  = in_a_valid & w_a_gate;
  assign in_a_ready   = out_a_ready & w_a_gate;
  assign out_a_source = r_a_locked ? r_a_slot : w_free_idx;
  assign w_a_fire     = in_a_valid & in_a_ready;
  assign w_alloc      = w_a_fire & ~r_a_locked;
  assign w_a_multi    = ((in_a_opcode == TL_A_PUT_FULL) || (in_a_opcode == TL_A_PUT_PARTIAL)) &&
                        (in_a_size > SIZE_W'(2));

  assign out_a_opcode  = in_a_opcode;
  assign out_a_param   = in_a_param;
  assign out_a_size    = in_a_size;
  assign out_a_address = in_a_address;
  assign out_a_mask    = in_a_mask;
  assign out_a_data    = in_a_data;
  assign out_a_corrupt = in_a_corrupt;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_a_locked <= 1'b0;
      r_a_slot   <= '0;
      r_a_cnt    <= '0;
    end else if (w_a_fire) begin
      if (r_a_locked) begin
        r_a_cnt <= r_a_cnt - TL_BEAT_CNT_W'(1);
        if (r_a_cnt == TL_BEAT_CNT_W'(1)) r_a_locked <= 1'b0;
      end else if (w_a_multi) begin
        r_a_locked <= 1'b1;
        r_a_slot   <= w_free_idx;
        r_a_cnt    <= tl_beats(in_a_size) - TL_BEAT_CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clock) begin
    if (w_alloc) r_src_tab[w_free_idx] <= in_a_source;
  end

`ifdef TL_SOURCE_SHRINK_CHECK_EN
  logic r_err_stray;

  assign w_d_stray   = ~w_valid[in_d_source];
  assign out_d_valid = in_d_valid & ~w_d_stray;
  assign in_d_ready  = out_d_ready | w_d_stray;
  assign err_stray   = r_err_stray;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)                    r_err_stray <= 1'b0;
    else if (in_d_valid & w_d_stray) r_err_stray <= 1'b1;
  end
`else
  assign w_d_stray   = 1'b0;
  assign out_d_valid = in_d_valid;
  assign in_d_ready  = out_d_ready;
`endif

  assign w_d_fire  = in_d_valid & in_d_ready & ~w_d_stray;
  assign w_d_multi = (in_d_opcode == TL_D_ACCESS_ACK_DATA) && (in_d_size > SIZE_W'(2));
  assign w_d_last  = (r_d_cnt == '0) ? ~w_d_multi : (r_d_cnt == TL_BEAT_CNT_W'(1));

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_d_cnt <= '0;
    end else if (w_d_fire) begin
      if (r_d_cnt == '0) begin
        if (w_d_multi) r_d_cnt <= tl_beats(in_d_size) - TL_BEAT_CNT_W'(1);
      end else begin
        r_d_cnt <= r_d_cnt - TL_BEAT_CNT_W'(1);
      end
    end
  end

  assign out_d_source  = r_src_tab[in_d_source];
  assign out_d_opcode  = in_d_opcode;
  assign out_d_param   = in_d_param;
  assign out_d_size    = in_d_size;
  assign out_d_sink    = in_d_sink;
  assign out_d_denied  = in_d_denied;
  assign out_d_corrupt = in_d_corrupt;
  assign out_d_data    = in_d_data;
  assign busy          = |w_valid;

endmodule
`default_nettype wire

// File: tb/tb_tl_source_shrinker.sv
`default_nettype none
//==============================================================================
// tb_tl_source_shrinker: directed plus randomized checks against a message-level model.
// Rev 1.0
//==============================================================================
module tb_tl_source_shrinker;
  import tl_shrink_pkg::*;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        in_a_valid, in_a_ready, out_a_valid, out_a_ready;
  logic [2:0]  in_a_opcode, in_a_param, in_a_size, out_a_opcode, out_a_param, out_a_size;
  logic [4:0]  in_a_source;
  logic [1:0]  out_a_source;
  logic [30:0] in_a_address, out_a_address;
  logic [3:0]  in_a_mask, out_a_mask;
  logic [31:0] in_a_data, out_a_data;
  logic        in_a_corrupt, out_a_corrupt;
  logic        in_d_valid, in_d_ready, out_d_valid, out_d_ready;
  logic [2:0]  in_d_opcode, in_d_size, out_d_opcode, out_d_size;
  logic [1:0]  in_d_param, out_d_param, in_d_source;
  logic [4:0]  out_d_source;
  logic        in_d_sink, in_d_denied, in_d_corrupt, out_d_sink, out_d_denied, out_d_corrupt;
  logic [31:0] in_d_data, out_d_data;
  logic        busy;
`ifdef TL_SOURCE_SHRINK_CHECK_EN
  logic        err_stray;
`endif

  always #5 clock = ~clock;

  tl_source_shrinker dut (
    .clock(clock), .reset_n(reset_n),
    .in_a_valid(in_a_valid), .in_a_ready(in_a_ready), .in_a_opcode(in_a_opcode),
    .in_a_param(in_a_param), .in_a_size(in_a_size), .in_a_source(in_a_source),
    .in_a_address(in_a_address), .in_a_mask(in_a_mask), .in_a_data(in_a_data),
    .in_a_corrupt(in_a_corrupt),
    .out_a_valid(out_a_valid), .out_a_ready(out_a_ready), .out_a_opcode(out_a_opcode),
    .out_a_param(out_a_param), .out_a_size(out_a_size), .out_a_source(out_a_source),
    .out_a_address(out_a_address), .out_a_mask(out_a_mask), .out_a_data(out_a_data),
    .out_a_corrupt(out_a_corrupt),
    .in_d_valid(in_d_valid), .in_d_ready(in_d_ready), .in_d_opcode(in_d_opcode),
    .in_d_param(in_d_param), .in_d_size(in_d_size), .in_d_source(in_d_source),
    .in_d_sink(in_d_sink), .in_d_denied(in_d_denied), .in_d_corrupt(in_d_corrupt),
    .in_d_data(in_d_data),
    .out_d_valid(out_d_valid), .out_d_ready(out_d_ready), .out_d_opcode(out_d_opcode),
    .out_d_param(out_d_param), .out_d_size(out_d_size), .out_d_source(out_d_source),
    .out_d_sink(out_d_sink), .out_d_denied(out_d_denied), .out_d_corrupt(out_d_corrupt),
    .out_d_data(out_d_data),
    .busy(busy)
`ifdef TL_SOURCE_SHRINK_CHECK_EN
    , .err_stray(err_stray)
`endif
  );

  // Reference model: which slots hold a request, the master source they hold,
  // and how many beats remain in the current A and D messages.
  bit [3:0]  m_valid;
  bit [4:0]  m_src [4];
  int        m_a_left, m_a_slot, m_d_left, m_d_slot;
  bit        m_err;
  int        tests = 0;
  int        fails = 0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int lowest_free();
    for (int i = 0; i < 4; i++) if (!m_valid[i]) return i;
    return -1;
  endfunction

  function automatic int msg_beats(input int size);
    return (size > 2) ? (1 << (size - 2)) : 1;
  endfunction

  task automatic drive_a(input bit v, input logic [2:0] op, input logic [2:0] sz, input logic [4:0] src);
    in_a_valid = v; in_a_opcode = op; in_a_size = sz; in_a_source = src;
    in_a_param = 3'($urandom); in_a_address = 31'($urandom); in_a_mask = 4'($urandom);
    in_a_data = $urandom; in_a_corrupt = 1'($urandom);
  endtask

  task automatic drive_d(input bit v, input logic [2:0] op, input logic [2:0] sz, input logic [1:0] src);
    in_d_valid = v; in_d_opcode = op; in_d_size = sz; in_d_source = src;
    in_d_param = 2'($urandom); in_d_sink = 1'($urandom); in_d_denied = 1'($urandom);
    in_d_corrupt = 1'($urandom); in_d_data = $urandom;
  endtask

  // Check all outputs for the currently driven inputs, then advance one clock.
  task automatic step();
    int fr, exp_as, n;
    bit full, exp_av, exp_ar, stray, exp_dv, exp_dr, a_fire, d_fire;
    #1;
    fr   = lowest_free();
    full = (fr < 0);
    if (m_a_left > 0) begin
      exp_av = in_a_valid; exp_ar = out_a_ready; exp_as = m_a_slot;
    end else begin
      exp_av = in_a_valid && !full; exp_ar = out_a_ready && !full; exp_as = full ? 0 : fr;
    end
    stray = 1'b0;
`ifdef TL_SOURCE_SHRINK_CHECK_EN
    stray = !m_valid[in_d_source];
    chk("err_stray", err_stray, m_err);
`endif
    exp_dv = in_d_valid && !stray;
    exp_dr = out_d_ready || stray;
    chk("a_valid", out_a_valid, exp_av);
    chk("a_ready", in_a_ready, exp_ar);
    if (exp_av) chk("a_source", out_a_source, exp_as);
    chk("a_fields", {out_a_opcode, out_a_param, out_a_size, out_a_address, out_a_mask, out_a_data, out_a_corrupt},
                    {in_a_opcode, in_a_param, in_a_size, in_a_address, in_a_mask, in_a_data, in_a_corrupt});
    chk("d_valid", out_d_valid, exp_dv);
    chk("d_ready", in_d_ready, exp_dr);
    if (exp_dv) chk("d_source", out_d_source, m_src[in_d_source]);
    chk("d_fields", {out_d_opcode, out_d_param, out_d_size, out_d_sink, out_d_denied, out_d_corrupt, out_d_data},
                    {in_d_opcode, in_d_param, in_d_size, in_d_sink, in_d_denied, in_d_corrupt, in_d_data});
    chk("busy", busy, |m_valid);
    a_fire = in_a_valid && exp_ar;
    d_fire = in_d_valid && exp_dr && !stray;
    if (in_d_valid && stray) m_err = 1'b1;
    @(posedge clock);
    if (d_fire) begin
      if (m_d_left == 0) begin
        n = (in_d_opcode == TL_D_ACCESS_ACK_DATA) ? msg_beats(int'(in_d_size)) : 1;
        m_d_left = n - 1;
        m_d_slot = int'(in_d_source);
      end else begin
        m_d_left--;
      end
      if (m_d_left == 0) m_valid[in_d_source] = 1'b0;
    end
    if (a_fire) begin
      if (m_a_left > 0) begin
        m_a_left--;
      end else begin
        m_valid[fr] = 1'b1;
        m_src[fr]   = in_a_source;
        if ((in_a_opcode == TL_A_PUT_FULL || in_a_opcode == TL_A_PUT_PARTIAL) && in_a_size > 3'd2) begin
          m_a_left = msg_beats(int'(in_a_size)) - 1;
          m_a_slot = fr;
        end
      end
    end
    @(negedge clock);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    drive_a(0, TL_A_GET, 3'd2, 5'd0);
    drive_d(0, TL_D_ACCESS_ACK, 3'd2, 2'd0);
    m_valid = '0; m_a_left = 0; m_d_left = 0; m_err = 1'b0;
    for (int i = 0; i < 2; i++) begin
      #1;
      chk("rst_busy", busy, 1'b0);
      chk("rst_a_valid", out_a_valid, 1'b0);
      chk("rst_d_valid", out_d_valid, 1'b0);
      @(negedge clock);
    end
    reset_n = 1'b1;
  endtask

  task automatic free_all();
    drive_a(0, TL_A_GET, 3'd2, 5'd0);
    out_d_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (m_valid[i]) begin
        drive_d(1, TL_D_ACCESS_ACK, 3'd2, 2'(i));
        step();
      end
    end
    drive_d(0, TL_D_ACCESS_ACK, 3'd2, 2'd0);
  endtask

  task automatic fill_table(input logic [4:0] base);
    out_a_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive_a(1, TL_A_GET, 3'd2, base + 5'(i * 7));
      step();
    end
    drive_a(0, TL_A_GET, 3'd2, 5'd0);
  endtask

  initial begin
    int cand[$];
    bit [2:0] ops[3] = '{TL_A_GET, TL_A_PUT_FULL, TL_A_PUT_PARTIAL};
    out_a_ready = 1'b1;
    out_d_ready = 1'b1;
    @(negedge clock);
    do_reset();

    // Single Get and its response.
    drive_a(1, TL_A_GET, 3'd2, 5'd17);
    #1 chk("tp1_a_src", out_a_source, 2'd0);
    step();
    drive_a(0, TL_A_GET, 3'd2, 5'd0);
    #1 chk("tp1_busy", busy, 1'b1);
    drive_d(1, TL_D_ACCESS_ACK_DATA, 3'd2, 2'd0);
    #1 chk("tp1_d_src", out_d_source, 5'd17);
    step();
    drive_d(0, TL_D_ACCESS_ACK, 3'd2, 2'd0);
    #1 chk("tp1_idle", busy, 1'b0);

    // Full table, then a response on slot 2 with a Get waiting.
    drive_a(1, TL_A_GET, 3'd2, 5'd3);  step();
    drive_a(1, TL_A_GET, 3'd2, 5'd9);  step();
    drive_a(1, TL_A_GET, 3'd2, 5'd22); step();
    drive_a(1, TL_A_GET, 3'd2, 5'd31); step();
    drive_a(1, TL_A_GET, 3'd2, 5'd12);
    #1 chk("tp2_full_ready", in_a_ready, 1'b0);
    step();
    drive_d(1, TL_D_ACCESS_ACK_DATA, 3'd2, 2'd2);
    #1 chk("tp2_d_src", out_d_source, 5'd22);
    chk("tp2_same_cycle_stall", in_a_ready, 1'b0);
    step();
    drive_d(0, TL_D_ACCESS_ACK, 3'd2, 2'd0);
    #1 chk("tp2_realloc_ready", in_a_ready, 1'b1);
    chk("tp2_realloc_src", out_a_source, 2'd2);
    step();
    free_all();

    // Four-beat PutFull with throttled slave A.
    drive_a(1, TL_A_PUT_FULL, 3'd4, 5'd5);
    for (int i = 0; i < 8; i++) begin
      out_a_ready = 1'(i % 2);
      #1 chk("tp3_src", out_a_source, 2'd0);
      step();
    end
    out_a_ready = 1'b1;
    drive_a(1, TL_A_GET, 3'd2, 5'd6);
    #1 chk("tp3_unlocked_src", out_a_source, 2'd1);
    drive_a(0, TL_A_GET, 3'd2, 5'd0);
    drive_d(1, TL_D_ACCESS_ACK, 3'd2, 2'd0);
    step();
    drive_d(0, TL_D_ACCESS_ACK, 3'd2, 2'd0);
    #1 chk("tp3_freed", busy, 1'b0);

    // Get of 16 bytes answered by four D beats.
    drive_a(1, TL_A_GET, 3'd4, 5'd7);
    step();
    drive_a(0, TL_A_GET, 3'd2, 5'd0);
    drive_d(1, TL_D_ACCESS_ACK_DATA, 3'd4, 2'd0);
    for (int i = 0; i < 4; i++) begin
      #1 chk("tp4_busy", busy, 1'b1);
      chk("tp4_d_src", out_d_source, 5'd7);
      step();
    end
    drive_d(0, TL_D_ACCESS_ACK, 3'd2, 2'd0);
    #1 chk("tp4_freed", busy, 1'b0);

    // Last D beat on slot 0 coinciding with a new A on a full table.
    fill_table(5'd1);
    drive_a(1, TL_A_GET, 3'd2, 5'd20);
    drive_d(1, TL_D_ACCESS_ACK, 3'd2, 2'd0);
    #1 chk("tp5_stall", in_a_ready, 1'b0);
    step();
    drive_d(0, TL_D_ACCESS_ACK, 3'd2, 2'd0);
    #1 chk("tp5_alloc_src", out_a_source, 2'd0);
    step();
    drive_a(0, TL_A_GET, 3'd2, 5'd0);
    free_all();

    // Randomized traffic.
    for (int cyc = 0; cyc < 400; cyc++) begin
      out_a_ready = ($urandom_range(0, 3) != 0);
      out_d_ready = ($urandom_range(0, 3) != 0);
      if (m_a_left > 0)
        drive_a(1'($urandom), in_a_opcode, in_a_size, in_a_source);
      else
        drive_a(1'($urandom), ops[$urandom_range(0, 2)], 3'($urandom_range(0, 4)), 5'($urandom));
      if (m_d_left > 0) begin
        drive_d(1'($urandom), in_d_opcode, in_d_size, 2'(m_d_slot));
      end else begin
        cand.delete();
        for (int i = 0; i < 4; i++)
          if (m_valid[i] && !(m_a_left > 0 && m_a_slot == i)) cand.push_back(i);
        if (cand.size() > 0)
          drive_d(1'($urandom), 3'($urandom_range(0, 1)), 3'($urandom_range(0, 4)),
                  2'(cand[$urandom_range(0, cand.size() - 1)]));
        else
          drive_d(0, TL_D_ACCESS_ACK, 3'd2, 2'($urandom));
      end
      step();
    end
    out_a_ready = 1'b1;
    out_d_ready = 1'b1;
    for (int k = 0; k < 64 && (m_a_left > 0 || m_d_left > 0); k++) begin
      drive_a(m_a_left > 0, in_a_opcode, in_a_size, in_a_source);
      drive_d(m_d_left > 0, in_d_opcode, in_d_size, 2'(m_d_slot));
      step();
    end
    free_all();
    #1 chk("rand_drained", busy, 1'b0);
    @(negedge clock);

`ifdef TL_SOURCE_SHRINK_CHECK_EN
    // Response to an idle slot is swallowed and flagged.
    drive_d(1, TL_D_ACCESS_ACK, 3'd2, 2'd1);
    #1 chk("stray_d_valid", out_d_valid, 1'b0);
    chk("stray_d_ready", in_d_ready, 1'b1);
    step();
    drive_d(0, TL_D_ACCESS_ACK, 3'd2, 2'd0);
    #1 chk("stray_sticky", err_stray, 1'b1);
    reset_n = 1'b0;
    #1 chk("stray_reset", err_stray, 1'b0);
    @(negedge clock);
    do_reset();
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
